jpeg_rle_symbolizer: RTL

- Converts one 8x8 block of quantized coefficients, arriving in zig-zag order, into baseline JPEG entropy symbols: DC difference, AC (run,size) pairs, ZRL and EOB.
- Sits directly downstream of the quantizer/zig-zag stage.
- Feeds the Huffman encoder through a valid/ready output register.
- The quantizer cones are pure combinational; this block is the first registered consumer of their results.

---
 rtl/jpeg_rle_symbolizer_if.sv | 29 ++
 rtl/jpeg_rle_symbolizer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle_symbolizer_if.sv
// Coefficient-in / symbol-out handshake bundle for the JPEG RLE symbolizer.
// The slave modport is the symbolizer; master is the upstream/downstream side.
interface jpeg_rle_symbolizer_if #(
   parameter int COEF_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [COEF_W-1:0] in_coef;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_run;
   logic [3:0]        out_size;
   logic [COEF_W:0]   out_amp;
   logic              out_dc;
   logic              out_zrl;
   logic              out_eob;

   modport slave (
      input  in_valid, in_coef, out_ready,
      output in_ready, out_valid, out_run, out_size,
      output out_amp, out_dc, out_zrl, out_eob
   );

   modport master (
      output in_valid, in_coef, out_ready,
      input  in_ready, out_valid, out_run, out_size,
      input  out_amp, out_dc, out_zrl, out_eob
   );
endinterface

// File: rtl/jpeg_rle_symbolizer.sv
// Turns a zig-zag ordered 8x8 block of quantized coefficients into
// baseline JPEG symbols (DC diff, AC run/size, ZRL, EOB) behind a 1-entry register.
module jpeg_rle_symbolizer #(
   parameter int COEF_W = 12,
   parameter int BLK_N  = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 restart,
   jpeg_rle_symbolizer_if.slave bus
);
   localparam int IW = $clog2(BLK_N);
   localparam logic [IW-1:0] LAST  = IW'(BLK_N - 1);
   localparam logic [IW-1:0] RUN16 = IW'(16);

   typedef enum logic {ACCEPT, ZRL} state_t;

   typedef struct packed {
      logic [3:0]      run;
      logic [3:0]      size;
      logic [COEF_W:0] amp;
      logic            dc;
      logic            zrl;
      logic            eob;
   } sym_t;

   state_t                   state;
   logic signed [COEF_W-1:0] pred;
   logic signed [COEF_W-1:0] hold;
   logic [IW-1:0]            idx;
   logic [IW-1:0]            run;
   logic                     valid;
   sym_t                     sym;

   logic                     fire;
   logic                     in_ready;
   logic                     take;
   logic                     is_dc;
   logic                     is_last;
   logic                     coef_zero;
   logic                     long_run;
   logic signed [COEF_W:0]   val;
   logic [3:0]               size;
   logic [COEF_W:0]          amp;

   function automatic logic [3:0] sym_size(
      input logic signed [COEF_W:0] v
   );
      logic [COEF_W:0] mag;
      mag = v[COEF_W] ? $unsigned(-v) : $unsigned(v);
      sym_size = '0;
      for (int i = 0; i <= COEF_W; i++)
         if (mag[i]) sym_size = 4'(i + 1);
   endfunction

   // Negative values use the ones'-complement form, i.e. v-1 masked.
   function automatic logic [COEF_W:0] sym_amp(
      input logic signed [COEF_W:0] v,
      input logic [3:0]             sz
   );
      logic [COEF_W:0] one;
      logic [COEF_W:0] mask;
      logic [COEF_W:0] t;
      one  = {{COEF_W{1'b0}}, 1'b1};
      mask = (one << sz) - one;
      t    = v[COEF_W] ? $unsigned(v) - one : $unsigned(v);
      sym_amp = t & mask;
   endfunction

   assign fire      = valid & bus.out_ready;
   assign in_ready  = (state == ACCEPT) && (!valid || bus.out_ready)
                      && !restart;
   assign take      = bus.in_valid & in_ready;
   assign is_dc     = (idx == '0);
   assign is_last   = (idx == LAST);
   assign coef_zero = (bus.in_coef == '0);
   assign long_run  = (run >= RUN16);

   always_comb begin
      val = '0;
      if (state == ZRL)
         val = {hold[COEF_W-1], hold};
      else if (is_dc)
         val = $signed({bus.in_coef[COEF_W-1], bus.in_coef})
             - $signed({pred[COEF_W-1], pred});
      else
         val = $signed({bus.in_coef[COEF_W-1], bus.in_coef});
      size = sym_size(val);
      amp  = sym_amp(val, size);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCEPT;
         pred  <= '0;
         hold  <= '0;
         idx   <= '0;
         run   <= '0;
         valid <= 1'b0;
         sym   <= '0;
      end else if (restart) begin
         state <= ACCEPT;
         pred  <= '0;
         idx   <= '0;
         run   <= '0;
         valid <= 1'b0;
         sym   <= '0;
      end else begin
         if (fire) valid <= 1'b0;
         unique case (state)
            ACCEPT: if (take) begin
               idx <= is_last ? '0 : idx + 1'b1;
               if (is_dc) begin
                  pred  <= bus.in_coef;
                  run   <= '0;
                  valid <= 1'b1;
                  sym   <= '{4'd0, size, amp, 1'b1, 1'b0, 1'b0};
               end else if (coef_zero) begin
                  // Trailing zeros collapse into EOB; pending run is dropped.
                  run <= is_last ? '0 : run + 1'b1;
                  if (is_last) begin
                     valid <= 1'b1;
                     sym   <= '{4'd0, 4'd0, '0, 1'b0, 1'b0, 1'b1};
                  end
               end else if (!long_run) begin
                  run   <= '0;
                  valid <= 1'b1;
                  sym   <= '{run[3:0], size, amp, 1'b0, 1'b0, 1'b0};
               end else begin
                  hold  <= bus.in_coef;
                  run   <= run - RUN16;
                  state <= ZRL;
                  valid <= 1'b1;
                  sym   <= '{4'd15, 4'd0, '0, 1'b0, 1'b1, 1'b0};
               end
            end
            ZRL: if (fire) begin
               valid <= 1'b1;
               if (long_run) begin
                  run <= run - RUN16;
                  sym <= '{4'd15, 4'd0, '0, 1'b0, 1'b1, 1'b0};
               end else begin
                  run   <= '0;
                  state <= ACCEPT;
                  sym   <= '{run[3:0], size, amp, 1'b0, 1'b0, 1'b0};
               end
            end
            default: state <= ACCEPT;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid;
   assign bus.out_run   = sym.run;
   assign bus.out_size  = sym.size;
   assign bus.out_amp   = sym.amp;
   assign bus.out_dc    = sym.dc;
   assign bus.out_zrl   = sym.zrl;
   assign bus.out_eob   = sym.eob;
endmodule
